mfcc_vq_fifo_ctrl: RTL and testbench

//  Frame-level scheduler around MFCC_VQ_FIFO (16b x 2048, 1-cycle read latency, no output reg).

---
 rtl/mfcc_vq_pkg.sv | 9 +
 rtl/mfcc_vq_rd_seq.sv | 66 ++++++
 rtl/mfcc_vq_fifo_ctrl.sv | 82 ++++++++
 tb/tb_mfcc_vq_fifo_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_vq_pkg.sv
// mfcc_vq_pkg: shared widths, frame geometry and FSM encodings for the MFCC-to-VQ FIFO scheduler
package mfcc_vq_pkg;
  localparam int DATA_W = 16;
  localparam int DEPTH_W = 11;
  localparam int FRAME_LEN = 13;
  localparam int FCNT_W = 8;
  typedef enum logic [1:0] {W_IDLE, W_PASS, W_DROP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DRAIN} r_state_t;
endpackage

// File: rtl/mfcc_vq_rd_seq.sv
// mfcc_vq_rd_seq: read FSM that commits one whole frame per request and streams it through a 2-stage vq pipe
module mfcc_vq_rd_seq
  import mfcc_vq_pkg::*;
#(
  parameter int DATA_W = mfcc_vq_pkg::DATA_W,
  parameter int FRAME_LEN = mfcc_vq_pkg::FRAME_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_ready,
  input  logic              vq_frame_req,
  output logic              commit,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              vq_valid,
  output logic              vq_first,
  output logic              vq_last,
  output logic [DATA_W-1:0] vq_data
);
  localparam int RCNT_W = $clog2(FRAME_LEN);
  r_state_t st;
  logic [RCNT_W-1:0] rcnt;
  logic p_valid, p_first, p_last;
  assign commit = st == R_IDLE && vq_frame_req && frame_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= R_IDLE;
      rcnt <= '0;
      fifo_rd_en <= 1'b0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last <= 1'b0;
      vq_valid <= 1'b0;
      vq_first <= 1'b0;
      vq_last <= 1'b0;
      vq_data <= '0;
    end else begin
      p_valid <= fifo_rd_en;
      p_first <= fifo_rd_en && rcnt == '0;
      p_last <= fifo_rd_en && rcnt == RCNT_W'(FRAME_LEN - 1);
      vq_valid <= p_valid;
      vq_first <= p_first;
      vq_last <= p_last;
      if (p_valid) vq_data <= fifo_rd_data;
      case (st)
        R_IDLE:
          if (commit) begin
            st <= R_READ;
            rcnt <= '0;
            fifo_rd_en <= 1'b1;
          end
        R_READ:
          if (rcnt == RCNT_W'(FRAME_LEN - 1)) begin
            st <= R_DRAIN;
            rcnt <= '0;
            fifo_rd_en <= 1'b0;
          end else rcnt <= rcnt + RCNT_W'(1);
        R_DRAIN:
          if (rcnt == RCNT_W'(1)) begin
            st <= R_IDLE;
            rcnt <= '0;
          end else rcnt <= rcnt + RCNT_W'(1);
        default: st <= R_IDLE;
      endcase
    end
endmodule

// File: rtl/mfcc_vq_fifo_ctrl.sv
// mfcc_vq_fifo_ctrl: admits or drops whole MFCC frames into the FIFO and hands committed frames to the VQ engine
module mfcc_vq_fifo_ctrl
  import mfcc_vq_pkg::*;
#(
  parameter int DATA_W = mfcc_vq_pkg::DATA_W,
  parameter int DEPTH_W = mfcc_vq_pkg::DEPTH_W,
  parameter int FRAME_LEN = mfcc_vq_pkg::FRAME_LEN,
  parameter int FCNT_W = mfcc_vq_pkg::FCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mfcc_valid,
  input  logic [DATA_W-1:0] mfcc_data,
  input  logic              mfcc_last,
  output logic              mfcc_ready,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              fifo_wr_full,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  input  logic              vq_frame_req,
  output logic              vq_valid,
  output logic [DATA_W-1:0] vq_data,
  output logic              vq_first,
  output logic              vq_last,
  output logic [FCNT_W-1:0] frames_avail,
  output logic              frame_drop,
  output logic              err_frame,
  output logic              err_fifo
);
  localparam int WCNT_W = $clog2(FRAME_LEN);
  localparam logic [DEPTH_W:0] OCC_MAX = (DEPTH_W + 1)'(2 ** DEPTH_W - FRAME_LEN);
  w_state_t wst;
  logic [WCNT_W-1:0] wcnt;
  logic [DEPTH_W:0] occ;
  logic take, word_last, pass, wr_last, commit;
  assign take = mfcc_valid && mfcc_ready;
  assign word_last = wcnt == WCNT_W'(FRAME_LEN - 1);
  assign pass = wst == W_PASS || (wst == W_IDLE && occ <= OCC_MAX);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mfcc_ready <= 1'b0;
      wst <= W_IDLE;
      wcnt <= '0;
      occ <= '0;
      fifo_wr_en <= 1'b0;
      fifo_wr_data <= '0;
      wr_last <= 1'b0;
      frame_drop <= 1'b0;
      frames_avail <= '0;
      err_frame <= 1'b0;
      err_fifo <= 1'b0;
    end else begin
      mfcc_ready <= 1'b1;
      fifo_wr_en <= take && pass;
      wr_last <= take && pass && word_last;
      frame_drop <= take && !pass && word_last;
      if (take && pass) fifo_wr_data <= mfcc_data;
      if (take) begin
        wcnt <= word_last ? '0 : wcnt + WCNT_W'(1);
        wst <= word_last ? W_IDLE : pass ? W_PASS : W_DROP;
        err_frame <= err_frame || (mfcc_last != word_last);
      end
      occ <= occ + (DEPTH_W + 1)'(fifo_wr_en) - (DEPTH_W + 1)'(fifo_rd_en);
      frames_avail <= frames_avail + FCNT_W'(wr_last) - FCNT_W'(commit);
      err_fifo <= err_fifo || (fifo_wr_en && fifo_wr_full) || (fifo_rd_en && fifo_rd_empty);
    end
  mfcc_vq_rd_seq #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) u_rd (
    .clk(clk),
    .rst(rst),
    .frame_ready(frames_avail != '0),
    .vq_frame_req(vq_frame_req),
    .commit(commit),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .vq_valid(vq_valid),
    .vq_first(vq_first),
    .vq_last(vq_last),
    .vq_data(vq_data)
  );
endmodule

// File: tb/tb_mfcc_vq_fifo_ctrl.sv
// tb_mfcc_vq_fifo_ctrl: randomized bench with a behavioural FIFO and a frame-order scoreboard
module tb_mfcc_vq_fifo_ctrl;
  import mfcc_vq_pkg::*;
  localparam int CAP = 2 ** DEPTH_W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mfcc_valid = 1'b0, mfcc_last = 1'b0, vq_frame_req = 1'b0;
  logic [DATA_W-1:0] mfcc_data = '0;
  logic mfcc_ready, fifo_wr_en, fifo_rd_en, vq_valid, vq_first, vq_last, frame_drop, err_frame, err_fifo;
  logic [DATA_W-1:0] fifo_wr_data, fifo_rd_data, vq_data;
  logic fifo_wr_full, fifo_rd_empty;
  logic [FCNT_W-1:0] frames_avail;
  logic [DATA_W-1:0] fq[$];
  logic [DATA_W-1:0] exp_q[$];
  bit rand_req = 1'b0;
  int n_chk = 0, n_err = 0;
  int n_wr = 0, n_rd = 0, n_drop = 0, n_vq = 0, n_rs = 0, cyc = 0, rd_idle = 0;
  logic prev_rd = 1'b0;
  logic [DATA_W+1:0] vq_log [4096];
  int cyc_log [4096];
  int gap_log [64];
  always #5 clk = ~clk;
  mfcc_vq_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .mfcc_valid(mfcc_valid), .mfcc_data(mfcc_data), .mfcc_last(mfcc_last), .mfcc_ready(mfcc_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .vq_frame_req(vq_frame_req), .vq_valid(vq_valid), .vq_data(vq_data), .vq_first(vq_first), .vq_last(vq_last),
    .frames_avail(frames_avail), .frame_drop(frame_drop), .err_frame(err_frame), .err_fifo(err_fifo)
  );
  always @(posedge clk or posedge rst)
    if (rst) begin
      fq.delete();
      fifo_rd_data <= '0;
      fifo_wr_full <= 1'b0;
      fifo_rd_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && fq.size() != 0) fifo_rd_data <= fq.pop_front();
      if (fifo_wr_en && fq.size() < CAP) fq.push_back(fifo_wr_data);
      fifo_wr_full <= fq.size() == CAP;
      fifo_rd_empty <= fq.size() == 0;
    end
  always @(negedge clk) begin
    cyc <= cyc + 1;
    n_wr <= n_wr + int'(fifo_wr_en);
    n_rd <= n_rd + int'(fifo_rd_en);
    n_drop <= n_drop + int'(frame_drop);
    if (vq_valid) begin
      vq_log[n_vq % 4096] <= {vq_first, vq_last, vq_data};
      cyc_log[n_vq % 4096] <= cyc;
      n_vq <= n_vq + 1;
    end
    if (fifo_rd_en && !prev_rd) begin
      gap_log[n_rs % 64] <= rd_idle;
      n_rs <= n_rs + 1;
    end
    rd_idle <= fifo_rd_en ? 0 : rd_idle + 1;
    prev_rd <= fifo_rd_en;
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_req) vq_frame_req = $urandom_range(0, 1) == 0;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
    mfcc_valid = 1'b1;
    mfcc_data = d;
    mfcc_last = l;
    tick();
    mfcc_valid = 1'b0;
    mfcc_last = 1'b0;
  endtask
  task automatic send_frame(input bit rnd, input logic [DATA_W-1:0] base, input int last_at, input int gap_max, input bit keep);
    logic [DATA_W-1:0] d;
    for (int i = 1; i <= FRAME_LEN; i++) begin
      d = rnd ? DATA_W'($urandom) : base - DATA_W'(i - 1);
      if (keep) exp_q.push_back(d);
      send_word(d, i == last_at);
      if (gap_max > 0 && i < FRAME_LEN) idle($urandom_range(0, gap_max));
    end
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    mfcc_valid = 1'b0;
    mfcc_last = 1'b0;
    vq_frame_req = 1'b0;
    rand_req = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask
  task automatic wait_words(input int target, input int budget);
    while (n_vq < target && budget > 0) begin
      tick();
      budget--;
    end
    n_chk++;
    if (n_vq < target) begin n_err++; $display("FAIL wait_vq: got %0d words, required %0d", n_vq, target); end
  endtask
  task automatic score_stream(input string tag, input int base, input int nw);
    logic [DATA_W+1:0] e;
    logic [DATA_W-1:0] x;
    for (int i = 0; i < nw; i++) begin
      e = vq_log[(base + i) % 4096];
      x = exp_q.pop_front();
      n_chk++;
      if (e[DATA_W-1:0] !== x) begin n_err++; $display("FAIL %s data[%0d]: got %h required %h", tag, i, e[DATA_W-1:0], x); end
      n_chk++;
      if (e[DATA_W+1:DATA_W] !== {i % FRAME_LEN == 0, i % FRAME_LEN == FRAME_LEN - 1}) begin
        n_err++; $display("FAIL %s first/last[%0d]: got %b", tag, i, e[DATA_W+1:DATA_W]);
      end
      if (i % FRAME_LEN != 0) begin
        n_chk++;
        if (cyc_log[(base + i) % 4096] - cyc_log[(base + i - 1) % 4096] !== 1) begin
          n_err++; $display("FAIL %s contiguity[%0d]: gap %0d required 1", tag, i, cyc_log[(base + i) % 4096] - cyc_log[(base + i - 1) % 4096]);
        end
      end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({mfcc_ready, fifo_wr_en, fifo_rd_en, vq_valid, vq_first, vq_last, frame_drop, err_frame, err_fifo} !== 9'b0) begin
      n_err++; $display("FAIL reset_flags: got %b required 0", {mfcc_ready, fifo_wr_en, fifo_rd_en, vq_valid, vq_first, vq_last, frame_drop, err_frame, err_fifo});
    end
    n_chk++;
    if (fifo_wr_data !== '0 || vq_data !== '0) begin n_err++; $display("FAIL reset_data: got %h/%h required 0", fifo_wr_data, vq_data); end
    n_chk++;
    if (frames_avail !== '0) begin n_err++; $display("FAIL reset_avail: got %0d required 0", frames_avail); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (mfcc_ready !== 1'b0) begin n_err++; $display("FAIL ready_early: got %b required 0", mfcc_ready); end
    @(negedge clk);
    n_chk++;
    if (mfcc_ready !== 1'b1) begin n_err++; $display("FAIL ready_after: got %b required 1", mfcc_ready); end
  endtask
  task automatic test_single_frame();
    int w0, v0;
    reset_dut();
    w0 = n_wr;
    v0 = n_vq;
    send_frame(1'b0, 16'hFFFF, FRAME_LEN, 0, 1'b1);
    idle(3);
    n_chk++;
    if (n_wr - w0 !== FRAME_LEN) begin n_err++; $display("FAIL single_writes: got %0d required %0d", n_wr - w0, FRAME_LEN); end
    n_chk++;
    if (frames_avail !== FCNT_W'(1)) begin n_err++; $display("FAIL single_avail: got %0d required 1", frames_avail); end
    vq_frame_req = 1'b1;
    tick();
    vq_frame_req = 1'b0;
    n_chk++;
    if (frames_avail !== '0) begin n_err++; $display("FAIL single_commit: got %0d required 0", frames_avail); end
    wait_words(v0 + FRAME_LEN, 40);
    idle(3);
    score_stream("single", v0, FRAME_LEN);
    n_chk++;
    if ({err_frame, err_fifo} !== 2'b00) begin n_err++; $display("FAIL single_errs: got %b required 00", {err_frame, err_fifo}); end
  endtask
  task automatic test_fill();
    int w0, d0;
    reset_dut();
    w0 = n_wr;
    d0 = n_drop;
    for (int f = 0; f < 158; f++) send_frame(1'b1, '0, FRAME_LEN, 0, 1'b0);
    idle(3);
    n_chk++;
    if (n_wr - w0 !== 157 * FRAME_LEN) begin n_err++; $display("FAIL fill_writes: got %0d required %0d", n_wr - w0, 157 * FRAME_LEN); end
    n_chk++;
    if (n_drop - d0 !== 1) begin n_err++; $display("FAIL fill_drops: got %0d required 1", n_drop - d0); end
    n_chk++;
    if (frames_avail !== FCNT_W'(157)) begin n_err++; $display("FAIL fill_avail: got %0d required 157", frames_avail); end
    n_chk++;
    if ({mfcc_ready, err_frame, err_fifo} !== 3'b100) begin n_err++; $display("FAIL fill_flags: got %b required 100", {mfcc_ready, err_frame, err_fifo}); end
  endtask
  task automatic test_same_cycle();
    int v0;
    reset_dut();
    v0 = n_vq;
    send_frame(1'b1, '0, FRAME_LEN, 0, 1'b1);
    idle(2);
    n_chk++;
    if (frames_avail !== FCNT_W'(1)) begin n_err++; $display("FAIL same_pre: got %0d required 1", frames_avail); end
    send_frame(1'b1, '0, FRAME_LEN, 0, 1'b1);
    vq_frame_req = 1'b1;
    n_chk++;
    if (fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL same_wr_last: got %b required 1", fifo_wr_en); end
    tick();
    vq_frame_req = 1'b0;
    n_chk++;
    if (frames_avail !== FCNT_W'(1)) begin n_err++; $display("FAIL same_avail: got %0d required 1", frames_avail); end
    n_chk++;
    if (fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL same_commit: got %b required 1", fifo_rd_en); end
    wait_words(v0 + FRAME_LEN, 40);
    idle(3);
    vq_frame_req = 1'b1;
    tick();
    vq_frame_req = 1'b0;
    wait_words(v0 + 2 * FRAME_LEN, 40);
    idle(3);
    score_stream("same", v0, 2 * FRAME_LEN);
    n_chk++;
    if (frames_avail !== '0) begin n_err++; $display("FAIL same_end: got %0d required 0", frames_avail); end
  endtask
  task automatic test_err_frame();
    int v0, d0;
    reset_dut();
    v0 = n_vq;
    d0 = n_drop;
    n_chk++;
    if (err_frame !== 1'b0) begin n_err++; $display("FAIL err_pre: got %b required 0", err_frame); end
    send_frame(1'b1, '0, 10, 0, 1'b1);
    n_chk++;
    if (err_frame !== 1'b1) begin n_err++; $display("FAIL err_set: got %b required 1", err_frame); end
    send_frame(1'b1, '0, FRAME_LEN, 0, 1'b1);
    idle(2);
    n_chk++;
    if (frames_avail !== FCNT_W'(2)) begin n_err++; $display("FAIL err_avail: got %0d required 2", frames_avail); end
    vq_frame_req = 1'b1;
    wait_words(v0 + 2 * FRAME_LEN, 80);
    vq_frame_req = 1'b0;
    idle(3);
    score_stream("err", v0, 2 * FRAME_LEN);
    n_chk++;
    if (n_drop - d0 !== 0 || err_fifo !== 1'b0) begin n_err++; $display("FAIL err_side: drops %0d err_fifo %b required 0/0", n_drop - d0, err_fifo); end
  endtask
  task automatic test_req_hold();
    int r0, s0, v0;
    reset_dut();
    r0 = n_rd;
    vq_frame_req = 1'b1;
    idle(20);
    n_chk++;
    if (n_rd - r0 !== 0) begin n_err++; $display("FAIL empty_req: got %0d reads required 0", n_rd - r0); end
    s0 = n_rs;
    v0 = n_vq;
    send_frame(1'b1, '0, FRAME_LEN, 2, 1'b1);
    send_frame(1'b1, '0, FRAME_LEN, 2, 1'b1);
    wait_words(v0 + 2 * FRAME_LEN, 200);
    vq_frame_req = 1'b0;
    idle(3);
    n_chk++;
    if (n_rs - s0 !== 2) begin n_err++; $display("FAIL hold_starts: got %0d required 2", n_rs - s0); end
    n_chk++;
    if (gap_log[(s0 + 1) % 64] < 3) begin n_err++; $display("FAIL hold_gap: got %0d required >=3", gap_log[(s0 + 1) % 64]); end
    score_stream("hold", v0, 2 * FRAME_LEN);
  endtask
  task automatic test_random();
    int v0;
    reset_dut();
    v0 = n_vq;
    rand_req = 1'b1;
    for (int f = 0; f < 10; f++) begin
      send_frame(1'b1, '0, FRAME_LEN, 3, 1'b1);
      idle($urandom_range(0, 4));
    end
    rand_req = 1'b0;
    vq_frame_req = 1'b1;
    wait_words(v0 + 10 * FRAME_LEN, 600);
    vq_frame_req = 1'b0;
    idle(3);
    score_stream("rand", v0, 10 * FRAME_LEN);
    n_chk++;
    if (frames_avail !== '0 || {err_frame, err_fifo} !== 2'b00) begin
      n_err++; $display("FAIL rand_end: avail %0d errs %b required 0/00", frames_avail, {err_frame, err_fifo});
    end
  endtask
  task automatic test_reset_mid_read();
    int v0, v1, r1;
    reset_dut();
    v0 = n_vq;
    send_frame(1'b1, '0, FRAME_LEN, 0, 1'b0);
    send_frame(1'b1, '0, FRAME_LEN, 0, 1'b0);
    idle(2);
    vq_frame_req = 1'b1;
    tick();
    vq_frame_req = 1'b0;
    wait_words(v0 + 5, 40);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({vq_valid, fifo_rd_en} !== 2'b00) begin n_err++; $display("FAIL rst_mid_out: got %b required 00", {vq_valid, fifo_rd_en}); end
    n_chk++;
    if (frames_avail !== '0) begin n_err++; $display("FAIL rst_mid_avail: got %0d required 0", frames_avail); end
    @(posedge clk);
    #1 rst = 1'b0;
    v1 = n_vq;
    r1 = n_rd;
    vq_frame_req = 1'b1;
    idle(20);
    vq_frame_req = 1'b0;
    n_chk++;
    if (n_vq - v1 !== 0 || n_rd - r1 !== 0) begin n_err++; $display("FAIL rst_stale: words %0d reads %0d required 0/0", n_vq - v1, n_rd - r1); end
    send_frame(1'b1, '0, FRAME_LEN, 0, 1'b1);
    idle(2);
    vq_frame_req = 1'b1;
    wait_words(v1 + FRAME_LEN, 60);
    vq_frame_req = 1'b0;
    idle(3);
    score_stream("post_rst", v1, FRAME_LEN);
  endtask
  initial begin
    test_reset();
    test_single_frame();
    test_fill();
    test_same_cycle();
    test_err_frame();
    test_req_hold();
    test_random();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
